lcd_hd44780_ctrl: RTL

LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

---
 rtl/lcd_hd44780_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 write-only controller with power-up init and host byte interface.
// Define LCD_4BIT_EN for nibble mode on lcd_data[7:4]; the default build drives the full 8-bit bus.
module lcd_hd44780_ctrl #(
    parameter int POWERUP_CYC  = 750000,
    parameter int SETUP_CYC    = 2,
    parameter int E_HIGH_CYC   = 25,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int LINES        = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);
    localparam int P_PWR = (POWERUP_CYC  < 1) ? 1 : POWERUP_CYC;
    localparam int P_SU  = (SETUP_CYC    < 1) ? 1 : SETUP_CYC;
    localparam int P_EH  = (E_HIGH_CYC   < 1) ? 1 : E_HIGH_CYC;
    localparam int P_CMD = (CMD_WAIT_CYC < 1) ? 1 : CMD_WAIT_CYC;
    localparam int P_CLR = (CLR_WAIT_CYC < 1) ? 1 : CLR_WAIT_CYC;
    localparam int M1    = (P_PWR > P_CLR) ? P_PWR : P_CLR;
    localparam int M2    = (M1 > P_CMD) ? M1 : P_CMD;
    localparam int M3    = (M2 > P_EH) ? M2 : P_EH;
    localparam int MAXC  = (M3 > P_SU) ? M3 : P_SU;
    localparam int CW    = (MAXC < 2) ? 1 : $clog2(MAXC);
`ifdef LCD_4BIT_EN
    localparam bit         NIB    = 1'b1;
    localparam logic [3:0] N_INIT = 4'd9;
    localparam logic [7:0] FSET   = (LINES >= 2) ? 8'h28 : 8'h20;
`else
    localparam bit         NIB    = 1'b0;
    localparam logic [3:0] N_INIT = 4'd5;
    localparam logic [7:0] FSET   = (LINES >= 2) ? 8'h38 : 8'h30;
`endif

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, PULSE, WAIT} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_idx;
    logic [7:0]    r_byte, r_data, w_ib;
    logic          r_rs, r_e, r_init_done, r_last;
    logic          w_done, w_accept, w_single, w_clr;
    int            w_len;

    assign wr_ready  = (r_state == IDLE) && r_init_done;
    assign init_done = r_init_done;
    assign lcd_e     = r_e;
    assign lcd_rs    = r_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = r_data;
    assign w_accept  = wr_valid && wr_ready;

    // Init table; in nibble mode four single-nibble wake-up writes come first.
    always_comb begin
`ifdef LCD_4BIT_EN
        w_ib     = (r_idx < 4'd3) ? 8'h30 : (r_idx == 4'd3) ? 8'h20 : (r_idx == 4'd4) ? FSET :
                   (r_idx == 4'd5) ? 8'h0C : (r_idx == 4'd6) ? 8'h06 : (r_idx == 4'd7) ? 8'h01 : 8'h80;
        w_single = r_idx < 4'd4;
`else
        w_ib     = (r_idx == 4'd0) ? FSET : (r_idx == 4'd1) ? 8'h0C : (r_idx == 4'd2) ? 8'h06 :
                   (r_idx == 4'd3) ? 8'h01 : 8'h80;
        w_single = 1'b1;
`endif
    end

    // Clear/home need the long wait; the gap between two nibbles of one byte never does.
    always_comb begin
        w_clr  = r_last && !r_rs && (r_byte inside {8'h01, 8'h02, 8'h03});
        w_len  = (r_state == PWRUP) ? P_PWR :
                 (r_state == SETUP) ? P_SU  :
                 (r_state == PULSE) ? P_EH  :
                 (r_state == WAIT)  ? (w_clr ? P_CLR : P_CMD) : 1;
        w_done = r_cnt == CW'(w_len - 1);
        w_next = r_state;
        case (r_state)
            PWRUP:   w_next = w_done ? INIT : PWRUP;
            INIT:    w_next = SETUP;
            IDLE:    w_next = w_accept ? SETUP : IDLE;
            SETUP:   w_next = w_done ? PULSE : SETUP;
            PULSE:   w_next = w_done ? WAIT : PULSE;
            WAIT:    w_next = !w_done ? WAIT : !r_last ? SETUP : (r_idx < N_INIT) ? INIT : IDLE;
            default: w_next = PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PWRUP;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_byte      <= '0;
            r_data      <= '0;
            r_rs        <= 1'b0;
            r_e         <= 1'b0;
            r_init_done <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || w_done) ? '0 : r_cnt + 1'b1;
            r_e     <= w_next == PULSE;
            if (w_next == IDLE)
                r_init_done <= 1'b1;
            if (r_state == INIT) begin
                r_idx  <= r_idx + 1'b1;
                r_byte <= w_ib;
                r_rs   <= 1'b0;
                r_data <= w_single ? w_ib : {w_ib[7:4], 4'h0};
                r_last <= w_single;
            end else if (w_accept) begin
                r_byte <= wr_data;
                r_rs   <= wr_rs;
                r_data <= NIB ? {wr_data[7:4], 4'h0} : wr_data;
                r_last <= !NIB;
            end else if (r_state == WAIT && w_done && !r_last) begin
                r_data <= {r_byte[3:0], 4'h0};
                r_last <= 1'b1;
            end
        end
    end
endmodule
